// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_pkg
//  Purpose  : Shared types for the BE context-switch sequencer: the FSM state
//             encoding, the per-thread architectural context record, and the
//             architectural widths the record is built from.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package bp_be_pkg;

   localparam int vaddr_width_gp = 64;
   localparam int asid_width_gp  = 16;

   // Machine mode; the redirect registers come out of reset pointing at M.
   localparam logic [1:0] c_priv_m = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      SAVE     = 3'd2,
      LOAD     = 3'd3,
      REDIRECT = 3'd4
   } bp_be_ctxt_sw_state_e;

   typedef struct packed {
      logic [vaddr_width_gp-1:0] npc;
      logic [1:0]                priv_mode;
      logic                      translation_en;
      logic [asid_width_gp-1:0]  asid;
   } bp_be_thread_ctx_s;

   function automatic bp_be_thread_ctx_s ctx_reset_value();
      bp_be_thread_ctx_s v;
      v.npc            = '0;
      v.priv_mode      = c_priv_m;
      v.translation_en = 1'b0;
      v.asid           = '0;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_context_switch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_context_switch_ctrl_if
//  Purpose  : Bundle of every non-clock/reset signal of the context-switch
//             sequencer. master = sequencer side, slave = surrounding BE
//             (CSR requester, pipeline status, context storage, FE redirect).
//  Ports    : switch_*      request handshake from the CTXT CSR write
//             pipe_empty_i  BE has no instructions in flight
//             run_*         live state of the running thread
//             commit_*      context storage write (save of the old thread)
//             current_thread_id_o / ctx_*  storage read select and read data
//             redirect_*    redirect to FE, valid/ready
//             flush_o, err_o
//  Revision : 1.0  initial release
// ============================================================================
interface bp_be_context_switch_ctrl_if #(
   parameter int num_threads_p = 1
) ();
   import bp_be_pkg::*;

   localparam int c_tid_width = $clog2(num_threads_p) + 1;

   logic                      switch_v_i;
   logic [c_tid_width-1:0]    switch_tid_i;
   logic                      switch_ready_o;
   logic                      pipe_empty_i;

   logic [vaddr_width_gp-1:0] run_npc_i;
   logic [1:0]                run_priv_mode_i;
   logic                      run_translation_en_i;
   logic [asid_width_gp-1:0]  run_asid_i;

   logic                      commit_v_o;
   logic [c_tid_width-1:0]    commit_thread_id_o;
   logic [vaddr_width_gp-1:0] commit_npc_o;
   logic [1:0]                commit_priv_mode_o;
   logic                      commit_translation_en_o;
   logic [asid_width_gp-1:0]  commit_asid_o;

   logic [c_tid_width-1:0]    current_thread_id_o;
   logic [vaddr_width_gp-1:0] ctx_npc_i;
   logic [1:0]                ctx_priv_mode_i;
   logic                      ctx_translation_en_i;
   logic [asid_width_gp-1:0]  ctx_asid_i;

   logic                      redirect_v_o;
   logic                      redirect_ready_i;
   logic [vaddr_width_gp-1:0] redirect_npc_o;
   logic [1:0]                redirect_priv_mode_o;
   logic                      redirect_translation_en_o;
   logic [asid_width_gp-1:0]  redirect_asid_o;

   logic                      flush_o;
   logic                      err_o;

   modport master (
      input  switch_v_i, switch_tid_i, pipe_empty_i,
             run_npc_i, run_priv_mode_i, run_translation_en_i, run_asid_i,
             ctx_npc_i, ctx_priv_mode_i, ctx_translation_en_i, ctx_asid_i,
             redirect_ready_i,
      output switch_ready_o,
             commit_v_o, commit_thread_id_o, commit_npc_o, commit_priv_mode_o,
             commit_translation_en_o, commit_asid_o,
             current_thread_id_o,
             redirect_v_o, redirect_npc_o, redirect_priv_mode_o,
             redirect_translation_en_o, redirect_asid_o,
             flush_o, err_o
   );

   modport slave (
      output switch_v_i, switch_tid_i, pipe_empty_i,
             run_npc_i, run_priv_mode_i, run_translation_en_i, run_asid_i,
             ctx_npc_i, ctx_priv_mode_i, ctx_translation_en_i, ctx_asid_i,
             redirect_ready_i,
      input  switch_ready_o,
             commit_v_o, commit_thread_id_o, commit_npc_o, commit_priv_mode_o,
             commit_translation_en_o, commit_asid_o,
             current_thread_id_o,
             redirect_v_o, redirect_npc_o, redirect_priv_mode_o,
             redirect_translation_en_o, redirect_asid_o,
             flush_o, err_o
   );

endinterface
`default_nettype wire

// File: rtl/bp_be_context_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bp_be_context_switch_ctrl
//  Purpose  : Hardware thread context-switch sequencer. Accepts a switch
//             request, flushes/drains the BE, saves the running thread's
//             NPC/priv/translation/ASID to context storage, reads the target
//             thread's context back and presents it to the FE as a redirect.
//             Owns the thread select driving the storage read port.
//  Ports    : clk_i    clock
//             reset_i  synchronous, active-high reset
//             io       bp_be_context_switch_ctrl_if.master (all other signals)
//  Revision : 1.0  initial release
// ============================================================================
module bp_be_context_switch_ctrl
   import bp_be_pkg::*;
#(
   parameter int num_threads_p   = 1,
   parameter int drain_timeout_p = 255
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   bp_be_context_switch_ctrl_if.master        io
);

   localparam int c_tid_width = $clog2(num_threads_p) + 1;
   localparam int c_cnt_width = (drain_timeout_p < 1) ? 1 : $clog2(drain_timeout_p + 1);

   localparam logic [c_tid_width-1:0] c_num_threads = c_tid_width'(num_threads_p);
   localparam logic [c_cnt_width-1:0] c_timeout     = c_cnt_width'(drain_timeout_p);

   bp_be_ctxt_sw_state_e      r_state, w_state_next;
   logic [c_tid_width-1:0]    r_cur_tid;
   logic [c_tid_width-1:0]    r_target;
   logic [c_cnt_width-1:0]    r_drain_cnt;
   logic                      r_err;
   bp_be_thread_ctx_s         r_redir;

   logic                      w_ready;
   logic                      w_accept;
   logic                      w_bad_tid;
   logic                      w_timeout;
   logic                      w_err_next;
   logic                      w_flush;
   logic                      w_commit_v;
   logic                      w_redirect_v;

   assign w_bad_tid = (io.switch_tid_i >= c_num_threads);
   assign w_timeout = (r_drain_cnt == c_timeout);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_err_next   = 1'b0;
      w_ready      = 1'b0;
      w_accept     = 1'b0;
      w_flush      = 1'b0;
      w_commit_v   = 1'b0;
      w_redirect_v = 1'b0;

      case (r_state)
         IDLE: begin
            w_ready  = 1'b1;
            w_accept = io.switch_v_i;
            if (w_accept) begin
               if (w_bad_tid) begin
                  w_err_next = 1'b1;
               end else begin
                  w_state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            w_flush = 1'b1;
            // An empty pipe wins over a simultaneous timeout: the save can
            // still complete safely, so there is no reason to abort.
            if (io.pipe_empty_i) begin
               w_state_next = SAVE;
            end else if (w_timeout) begin
               w_err_next   = 1'b1;
               w_state_next = IDLE;
            end
         end
         SAVE: begin
            w_flush      = 1'b1;
            w_commit_v   = 1'b1;
            w_state_next = LOAD;
         end
         LOAD: begin
            w_flush      = 1'b1;
            w_state_next = REDIRECT;
         end
         REDIRECT: begin
            // Flush stays high through the handshake cycle so nothing from
            // the old thread can slip in before the FE takes the redirect.
            w_flush      = 1'b1;
            w_redirect_v = 1'b1;
            if (io.redirect_ready_i) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers: target latch, drain counter, thread id, redirect
   // capture, error pulse
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_target    <= '0;
         r_drain_cnt <= '0;
         r_cur_tid   <= '0;
         r_redir     <= ctx_reset_value();
         r_err       <= 1'b0;
      end else begin
         r_err <= w_err_next;

         if (w_accept && !w_bad_tid) begin
            r_target <= io.switch_tid_i;
         end

         // Clear-on-accept, saturating up-counter; it stops at the timeout
         // value rather than wrapping so a long drain can never alias to 0.
         if (w_accept) begin
            r_drain_cnt <= '0;
         end else if ((r_state == DRAIN) && !w_timeout) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
         end

         // Switching the thread select at the end of SAVE makes the storage
         // read data in LOAD belong to the target thread. For a self-switch
         // the storage write lands on the same edge, so LOAD sees the
         // just-saved state.
         if (r_state == SAVE) begin
            r_cur_tid <= r_target;
         end

         if (r_state == LOAD) begin
            r_redir.npc            <= io.ctx_npc_i;
            r_redir.priv_mode      <= io.ctx_priv_mode_i;
            r_redir.translation_en <= io.ctx_translation_en_i;
            r_redir.asid           <= io.ctx_asid_i;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign io.switch_ready_o            = w_ready;
   assign io.flush_o                   = w_flush;
   assign io.err_o                     = r_err;

   assign io.commit_v_o                = w_commit_v;
   assign io.commit_thread_id_o        = r_cur_tid;
   assign io.commit_npc_o              = io.run_npc_i;
   assign io.commit_priv_mode_o        = io.run_priv_mode_i;
   assign io.commit_translation_en_o   = io.run_translation_en_i;
   assign io.commit_asid_o             = io.run_asid_i;

   assign io.current_thread_id_o       = r_cur_tid;

   assign io.redirect_v_o              = w_redirect_v;
   assign io.redirect_npc_o            = r_redir.npc;
   assign io.redirect_priv_mode_o      = r_redir.priv_mode;
   assign io.redirect_translation_en_o = r_redir.translation_en;
   assign io.redirect_asid_o           = r_redir.asid;

endmodule
`default_nettype wire

// File: tb/tb_bp_be_context_switch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_be_context_switch_ctrl
//  Purpose  : Directed self-checking bench for bp_be_context_switch_ctrl.
//             dut_a: 4 threads, default drain timeout, with a context
//             storage model. dut_b: 4 threads, drain timeout 8, pipe never
//             empties.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_bp_be_context_switch_ctrl;
   import bp_be_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   bp_be_context_switch_ctrl_if #(.num_threads_p(4)) ifa ();
   bp_be_context_switch_ctrl_if #(.num_threads_p(4)) ifb ();

   bp_be_context_switch_ctrl #(.num_threads_p(4), .drain_timeout_p(255)) dut_a (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (ifa)
   );

   bp_be_context_switch_ctrl #(.num_threads_p(4), .drain_timeout_p(8)) dut_b (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Context storage model for dut_a: written by commit, read combinationally
   // by current_thread_id_o. Reset loads the per-thread initial contexts.
   logic [63:0] m_npc   [0:7];
   logic [1:0]  m_priv  [0:7];
   logic        m_tr    [0:7];
   logic [15:0] m_asid  [0:7];

   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 8; k++) begin
            m_npc[k]  <= 64'h8000_0000 + 64'(k) * 64'h1000;
            m_priv[k] <= 2'(k % 4);
            m_tr[k]   <= 1'b1;
            m_asid[k] <= 16'h0011 * 16'(k);
         end
         m_priv[2] <= 2'b00;
      end else if (ifa.commit_v_o) begin
         m_npc[ifa.commit_thread_id_o]  <= ifa.commit_npc_o;
         m_priv[ifa.commit_thread_id_o] <= ifa.commit_priv_mode_o;
         m_tr[ifa.commit_thread_id_o]   <= ifa.commit_translation_en_o;
         m_asid[ifa.commit_thread_id_o] <= ifa.commit_asid_o;
      end
   end

   assign ifa.ctx_npc_i            = m_npc[ifa.current_thread_id_o];
   assign ifa.ctx_priv_mode_i      = m_priv[ifa.current_thread_id_o];
   assign ifa.ctx_translation_en_i = m_tr[ifa.current_thread_id_o];
   assign ifa.ctx_asid_i           = m_asid[ifa.current_thread_id_o];

   assign ifb.ctx_npc_i            = '0;
   assign ifb.ctx_priv_mode_i      = '0;
   assign ifb.ctx_translation_en_i = 1'b0;
   assign ifb.ctx_asid_i           = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are then driven and outputs checked 2-3 ns
   // after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_run(input logic [63:0] npc, input logic [1:0] priv,
                          input logic tr, input logic [15:0] asid);
      ifa.run_npc_i            = npc;
      ifa.run_priv_mode_i      = priv;
      ifa.run_translation_en_i = tr;
      ifa.run_asid_i           = asid;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int err_cnt;
      int err_cyc;
      int com_cnt;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      ifa.switch_v_i = 1'b0; ifa.switch_tid_i = '0; ifa.pipe_empty_i = 1'b1;
      ifa.redirect_ready_i = 1'b0;
      set_run(64'h0, 2'b11, 1'b0, 16'h0);
      ifb.switch_v_i = 1'b0; ifb.switch_tid_i = '0; ifb.pipe_empty_i = 1'b0;
      ifb.redirect_ready_i = 1'b1;
      ifb.run_npc_i = '0; ifb.run_priv_mode_i = '0;
      ifb.run_translation_en_i = 1'b0; ifb.run_asid_i = '0;

      // ---------------- reset state ----------------
      step(); step();
      #1;
      check_eq("rst_ready",    64'(ifa.switch_ready_o), 64'd1);
      check_eq("rst_flush",    64'(ifa.flush_o), 64'd0);
      check_eq("rst_err",      64'(ifa.err_o), 64'd0);
      check_eq("rst_commit_v", 64'(ifa.commit_v_o), 64'd0);
      check_eq("rst_redir_v",  64'(ifa.redirect_v_o), 64'd0);
      check_eq("rst_cur_tid",  64'(ifa.current_thread_id_o), 64'd0);
      check_eq("rst_redir_npc",  ifa.redirect_npc_o, 64'd0);
      check_eq("rst_redir_priv", 64'(ifa.redirect_priv_mode_o), 64'd3);
      check_eq("rst_redir_tr",   64'(ifa.redirect_translation_en_o), 64'd0);
      reset = 1'b0;
      step();

      // ---------------- test 1: 0 -> 2, pipe already empty ----------------
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd2; #1;
      check_eq("t1_c0_ready", 64'(ifa.switch_ready_o), 64'd1);
      step();                                   // cycle 1: DRAIN
      ifa.switch_v_i = 1'b0; #1;
      check_eq("t1_c1_flush", 64'(ifa.flush_o), 64'd1);
      check_eq("t1_c1_ready", 64'(ifa.switch_ready_o), 64'd0);
      step();                                   // cycle 2: SAVE
      set_run(64'h8000_0100, 2'b11, 1'b0, 16'h0011); #1;
      check_eq("t1_c2_commit_v",   64'(ifa.commit_v_o), 64'd1);
      check_eq("t1_c2_commit_tid", 64'(ifa.commit_thread_id_o), 64'd0);
      check_eq("t1_c2_commit_npc", ifa.commit_npc_o, 64'h8000_0100);
      check_eq("t1_c2_commit_asid", 64'(ifa.commit_asid_o), 64'h0011);
      step();                                   // cycle 3: LOAD
      set_run(64'hDEAD_BEEF, 2'b01, 1'b1, 16'hFFFF); #1;
      check_eq("t1_c3_cur_tid",  64'(ifa.current_thread_id_o), 64'd2);
      check_eq("t1_c3_commit_v", 64'(ifa.commit_v_o), 64'd0);
      step();                                   // cycle 4: REDIRECT
      ifa.redirect_ready_i = 1'b1; #1;
      check_eq("t1_c4_redir_v",    64'(ifa.redirect_v_o), 64'd1);
      check_eq("t1_c4_redir_npc",  ifa.redirect_npc_o, 64'h8000_2000);
      check_eq("t1_c4_redir_priv", 64'(ifa.redirect_priv_mode_o), 64'd0);
      check_eq("t1_c4_redir_asid", 64'(ifa.redirect_asid_o), 64'h0022);
      check_eq("t1_c4_flush",      64'(ifa.flush_o), 64'd1);
      step();                                   // cycle 5: IDLE
      ifa.redirect_ready_i = 1'b0; #1;
      check_eq("t1_c5_flush",   64'(ifa.flush_o), 64'd0);
      check_eq("t1_c5_redir_v", 64'(ifa.redirect_v_o), 64'd0);
      check_eq("t1_c5_ready",   64'(ifa.switch_ready_o), 64'd1);

      // ---------------- self-switch 2 -> 2: redirect returns saved state ----
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd2;
      step();
      ifa.switch_v_i = 1'b0;
      step();                                   // SAVE
      set_run(64'h8000_0A00, 2'b01, 1'b1, 16'h00AA); #1;
      check_eq("self_commit_tid", 64'(ifa.commit_thread_id_o), 64'd2);
      step(); step();                           // LOAD, REDIRECT
      ifa.redirect_ready_i = 1'b1; #1;
      check_eq("self_redir_npc",  ifa.redirect_npc_o, 64'h8000_0A00);
      check_eq("self_redir_priv", 64'(ifa.redirect_priv_mode_o), 64'd1);
      check_eq("self_redir_asid", 64'(ifa.redirect_asid_o), 64'h00AA);
      step();
      ifa.redirect_ready_i = 1'b0;

      // ---------------- test 2: 2 -> 1, pipe busy 10 cycles ----------------
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd1; ifa.pipe_empty_i = 1'b0;
      step();                                   // cycle 1
      ifa.switch_v_i = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         #1;
         check_eq($sformatf("t2_drain%0d_flush", i), 64'(ifa.flush_o), 64'd1);
         check_eq($sformatf("t2_drain%0d_commit", i), 64'(ifa.commit_v_o), 64'd0);
         step();
      end
      ifa.pipe_empty_i = 1'b1; #1;              // cycle 11
      check_eq("t2_c11_flush", 64'(ifa.flush_o), 64'd1);
      step();                                   // cycle 12: SAVE
      set_run(64'h8000_0B00, 2'b00, 1'b1, 16'h00BB); #1;
      check_eq("t2_c12_commit_v",   64'(ifa.commit_v_o), 64'd1);
      check_eq("t2_c12_commit_tid", 64'(ifa.commit_thread_id_o), 64'd2);
      step();                                   // cycle 13: LOAD
      #1;
      check_eq("t2_c13_redir_v", 64'(ifa.redirect_v_o), 64'd0);
      step();                                   // cycle 14: REDIRECT
      ifa.redirect_ready_i = 1'b1; #1;
      check_eq("t2_c14_redir_v",   64'(ifa.redirect_v_o), 64'd1);
      check_eq("t2_c14_redir_npc", ifa.redirect_npc_o, 64'h8000_1000);
      step();
      ifa.redirect_ready_i = 1'b0;

      // ---------------- test 3: bad tid 5 ----------------
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd5; #1;
      check_eq("t3_c0_err", 64'(ifa.err_o), 64'd0);
      step();
      ifa.switch_v_i = 1'b0; #1;
      check_eq("t3_c1_err",     64'(ifa.err_o), 64'd1);
      check_eq("t3_c1_ready",   64'(ifa.switch_ready_o), 64'd1);
      check_eq("t3_c1_flush",   64'(ifa.flush_o), 64'd0);
      check_eq("t3_c1_commit",  64'(ifa.commit_v_o), 64'd0);
      step(); #1;
      check_eq("t3_c2_err",     64'(ifa.err_o), 64'd0);
      check_eq("t3_c2_commit",  64'(ifa.commit_v_o), 64'd0);
      check_eq("t3_c2_cur_tid", 64'(ifa.current_thread_id_o), 64'd1);

      // ---------------- test 5: 1 -> 3, FE stalls redirect 6 cycles --------
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd3;
      step(); ifa.switch_v_i = 1'b0;
      step(); step(); step();                   // SAVE, LOAD, REDIRECT
      for (int i = 0; i < 6; i++) begin
         ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd0;
         set_run(64'(i), 2'(i), 1'b0, 16'(i)); #1;
         check_eq($sformatf("t5_hold%0d_redir_v", i), 64'(ifa.redirect_v_o), 64'd1);
         check_eq($sformatf("t5_hold%0d_npc", i), ifa.redirect_npc_o, 64'h8000_3000);
         check_eq($sformatf("t5_hold%0d_priv", i), 64'(ifa.redirect_priv_mode_o), 64'd3);
         check_eq($sformatf("t5_hold%0d_asid", i), 64'(ifa.redirect_asid_o), 64'h0033);
         check_eq($sformatf("t5_hold%0d_ready", i), 64'(ifa.switch_ready_o), 64'd0);
         step();
      end
      ifa.switch_v_i = 1'b0; ifa.redirect_ready_i = 1'b1;
      step();
      ifa.redirect_ready_i = 1'b0; #1;
      check_eq("t5_done_ready",   64'(ifa.switch_ready_o), 64'd1);
      check_eq("t5_done_cur_tid", 64'(ifa.current_thread_id_o), 64'd3);

      // ---------------- test 6: reset during LOAD (3 -> 2) ----------------
      ifa.switch_v_i = 1'b1; ifa.switch_tid_i = 3'd2;
      step(); ifa.switch_v_i = 1'b0;
      step(); step();                           // SAVE, LOAD
      reset = 1'b1;
      step(); #1;
      check_eq("t6_cur_tid",   64'(ifa.current_thread_id_o), 64'd0);
      check_eq("t6_redir_v",   64'(ifa.redirect_v_o), 64'd0);
      check_eq("t6_flush",     64'(ifa.flush_o), 64'd0);
      check_eq("t6_commit_v",  64'(ifa.commit_v_o), 64'd0);
      check_eq("t6_ready",     64'(ifa.switch_ready_o), 64'd1);
      check_eq("t6_redir_npc", ifa.redirect_npc_o, 64'd0);
      check_eq("t6_redir_priv", 64'(ifa.redirect_priv_mode_o), 64'd3);
      reset = 1'b0;
      step();

      // ---------------- test 4: drain timeout 8 on dut_b ----------------
      err_cnt = 0; err_cyc = -1; com_cnt = 0;
      ifb.switch_v_i = 1'b1; ifb.switch_tid_i = 3'd1;
      step(); ifb.switch_v_i = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         #1;
         if (ifb.err_o) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = c;
         end
         if (ifb.commit_v_o) com_cnt++;
         if (c == 9) check_eq("t4_c9_flush", 64'(ifb.flush_o), 64'd1);
         if (c == 10) begin
            check_eq("t4_c10_ready", 64'(ifb.switch_ready_o), 64'd1);
            check_eq("t4_c10_flush", 64'(ifb.flush_o), 64'd0);
         end
         step();
      end
      check_eq("t4_err_count", 64'(err_cnt), 64'd1);
      check_eq("t4_err_cycle", 64'(err_cyc), 64'd10);
      check_eq("t4_commits",   64'(com_cnt), 64'd0);
      check_eq("t4_cur_tid",   64'(ifb.current_thread_id_o), 64'd0);
      check_eq("t4_ready",     64'(ifb.switch_ready_o), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
